acc_ctrl_fsm: RTL



---
 rtl/acc_pkg.sv | 70 +++++++
 rtl/acc_ctrl_decode.sv | 20 ++
 rtl/acc_ctrl_fsm.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/acc_pkg.sv
// Shared constants for the accumulator core control: opcodes, ALU operations,
// datapath select encodings, FSM state codes and the instruction class type.
package acc_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_SLL  = 4'h5;
  localparam logic [3:0] OP_SRL  = 4'h6;
  localparam logic [3:0] OP_SRA  = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_BNE  = 4'h9;
  localparam logic [3:0] OP_BLT  = 4'hA;
  localparam logic [3:0] OP_BGE  = 4'hB;
  localparam logic [3:0] OP_LW   = 4'hC;
  localparam logic [3:0] OP_SW   = 4'hD;
  localparam logic [3:0] OP_LI   = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  // ALU operation codes line up with the opcodes for ALU and branch instructions.
  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_OR  = 4'h3;
  localparam logic [3:0] ALU_XOR = 4'h4;
  localparam logic [3:0] ALU_SLL = 4'h5;
  localparam logic [3:0] ALU_SRL = 4'h6;
  localparam logic [3:0] ALU_SRA = 4'h7;
  localparam logic [3:0] ALU_BEQ = 4'h8;
  localparam logic [3:0] ALU_BNE = 4'h9;
  localparam logic [3:0] ALU_BLT = 4'hA;
  localparam logic [3:0] ALU_BGE = 4'hB;

  localparam logic [1:0] SRCA_ACC  = 2'd0;
  localparam logic [1:0] SRCA_PC   = 2'd1;
  localparam logic [1:0] SRCA_ZERO = 2'd2;

  localparam logic [1:0] SRCB_IMM  = 2'd0;
  localparam logic [1:0] SRCB_ONE  = 2'd1;
  localparam logic [1:0] SRCB_ZERO = 2'd2;

  localparam logic ACC_FROM_ALU = 1'b0;
  localparam logic ACC_FROM_MEM = 1'b1;

  localparam logic ADDR_PC  = 1'b0;
  localparam logic ADDR_IMM = 1'b1;

  typedef logic [2:0] acc_state_t;

  localparam acc_state_t S_FETCH  = 3'd0;
  localparam acc_state_t S_DECODE = 3'd1;
  localparam acc_state_t S_EXEC   = 3'd2;
  localparam acc_state_t S_MEM    = 3'd3;
  localparam acc_state_t S_BR_CMP = 3'd4;
  localparam acc_state_t S_BR_TGT = 3'd5;
  localparam acc_state_t S_HALT   = 3'd6;
  localparam acc_state_t S_FAULT  = 3'd7;

  typedef enum logic [2:0] {
    CLS_ALU    = 3'd0,
    CLS_LI     = 3'd1,
    CLS_LOAD   = 3'd2,
    CLS_STORE  = 3'd3,
    CLS_BRANCH = 3'd4,
    CLS_HALT   = 3'd5
  } acc_class_t;

endpackage

// File: rtl/acc_ctrl_decode.sv
// Combinational opcode classifier used by the accumulator control FSM.
module acc_ctrl_decode
  import acc_pkg::*;
(
  input  logic [3:0] opcode,
  output acc_class_t cls
);

  always_comb begin
    cls = CLS_HALT;
    case (opcode)
      OP_LW:   cls = CLS_LOAD;
      OP_SW:   cls = CLS_STORE;
      OP_LI:   cls = CLS_LI;
      OP_HALT: cls = CLS_HALT;
      default: cls = opcode[3] ? CLS_BRANCH : CLS_ALU;
    endcase
  end

endmodule

// File: rtl/acc_ctrl_fsm.sv
// Multi-cycle control FSM for the 16-bit accumulator core.
// Define ACC_CTRL_PERF_EN to add the InstRetired counter output.
module acc_ctrl_fsm
  import acc_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255,
  parameter int TMR_W       = 8
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [15:0] Instr,
  input  logic        ShouldBranch,
  input  logic        MemAck,
  output logic [3:0]  ALUOp,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic        AccSrc,
  output logic        AccWrite,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        MemReq,
  output logic        MemWE,
  output logic        MemAddrSel,
  output logic        Halted,
  output logic        Fault
`ifdef ACC_CTRL_PERF_EN
  ,
  output logic [15:0] InstRetired
`endif
);

  localparam logic [TMR_W-1:0] TO_LAST =
    (ACK_TIMEOUT == 0) ? '0 : TMR_W'(ACK_TIMEOUT - 1);

  acc_state_t       state, state_nxt;
  acc_class_t       cls;
  logic [3:0]       opcode;
  logic             started;
  logic             taken;
  logic [TMR_W-1:0] wait_cnt;
  logic             req, ack, timeout;
  logic             unused_imm;

  assign opcode     = Instr[15:12];
  // The immediate field only feeds the datapath, never the control.
  assign unused_imm = ^Instr[11:0];

  acc_ctrl_decode u_decode (
    .opcode (opcode),
    .cls    (cls)
  );

  // started keeps MemReq low in the first FETCH cycle after reset.
  assign req     = started && (state == S_FETCH || state == S_MEM);
  assign ack     = req && MemAck;
  assign timeout = (ACK_TIMEOUT != 0) && req && !MemAck && (wait_cnt == TO_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH: begin
        if (ack)          state_nxt = S_DECODE;
        else if (timeout) state_nxt = S_FAULT;
      end
      S_DECODE: begin
        case (cls)
          CLS_ALU, CLS_LI:     state_nxt = S_EXEC;
          CLS_LOAD, CLS_STORE: state_nxt = S_MEM;
          CLS_BRANCH:          state_nxt = S_BR_CMP;
          default:             state_nxt = S_HALT;
        endcase
      end
      S_EXEC:   state_nxt = S_FETCH;
      S_MEM: begin
        if (ack)          state_nxt = S_FETCH;
        else if (timeout) state_nxt = S_FAULT;
      end
      S_BR_CMP: state_nxt = S_BR_TGT;
      S_BR_TGT: state_nxt = S_FETCH;
      default:  state_nxt = state;
    endcase
  end

  always_comb begin
    ALUOp      = ALU_ADD;
    ALUSrcA    = SRCA_ACC;
    ALUSrcB    = SRCB_IMM;
    AccSrc     = ACC_FROM_ALU;
    AccWrite   = 1'b0;
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    MemReq     = 1'b0;
    MemWE      = 1'b0;
    MemAddrSel = ADDR_PC;
    Halted     = 1'b0;
    Fault      = 1'b0;
    case (state)
      S_FETCH: begin
        MemReq = req;
        if (ack) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          ALUSrcA = SRCA_PC;
          ALUSrcB = SRCB_ONE;
        end
      end
      S_EXEC: begin
        AccWrite = 1'b1;
        if (cls == CLS_LI) ALUSrcA = SRCA_ZERO;
        else               ALUOp   = opcode;
      end
      S_MEM: begin
        MemReq     = req;
        MemAddrSel = ADDR_IMM;
        MemWE      = req && (cls == CLS_STORE);
        if (ack && cls == CLS_LOAD) begin
          AccSrc   = ACC_FROM_MEM;
          AccWrite = 1'b1;
        end
      end
      S_BR_CMP: begin
        ALUOp   = opcode;
        ALUSrcB = SRCB_ZERO;
      end
      // ALUOut from BR_CMP is discarded; PC already holds fetch PC + 1.
      S_BR_TGT: begin
        ALUSrcA = SRCA_PC;
        PCWrite = taken;
      end
      S_HALT:  Halted = 1'b1;
      S_FAULT: Fault  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= S_FETCH;
      started  <= 1'b0;
      taken    <= 1'b0;
      wait_cnt <= '0;
    end else begin
      state   <= state_nxt;
      started <= 1'b1;
      if (state == S_BR_CMP) taken <= ShouldBranch;
      if (ack || (state_nxt != state && (state_nxt == S_FETCH || state_nxt == S_MEM)))
        wait_cnt <= '0;
      else if (req)
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

`ifdef ACC_CTRL_PERF_EN
  logic retire;

  assign retire = (state != S_FETCH && state_nxt == S_FETCH) ||
                  (state == S_DECODE && state_nxt == S_HALT);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)      InstRetired <= '0;
    else if (retire) InstRetired <= InstRetired + 16'd1;
  end
`endif

endmodule
